// File: rtl/csa_mult_seq_pkg.sv
// Shared types and helpers for the carry-save iterative multiplier.
package csa_mult_seq_pkg;

   // Controller states: accept, fold partial products, resolve, hold result
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REDUCE = 2'd1,
      ST_FINAL  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // Supported partial-product folding rates (one or two chained CSA rows)
   localparam int unsigned PP_ONE = 1;
   localparam int unsigned PP_TWO = 2;

   // Width of a counter that must hold values 0..n-1 (never narrower than 1)
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/csa_mult_sequencer_csa_row.sv
// One 3:2 carry-save row: sum = a^b^c, carry = majority(a,b,c) shifted left.
// The carry out of the top bit is dropped, so the pair is modulo 2^W.
module csa_row #(
   parameter int unsigned W = 64
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic [W-1:0] c_i,
   output logic [W-1:0] sum_o,
   output logic [W-1:0] carry_o
);

   assign sum_o   = a_i ^ b_i ^ c_i;
   // Only the low W-1 majority bits survive the left shift
   assign carry_o = {(a_i[W-2:0] & b_i[W-2:0]) |
                     (a_i[W-2:0] & c_i[W-2:0]) |
                     (b_i[W-2:0] & c_i[W-2:0]), 1'b0};

endmodule

// File: rtl/csa_mult_sequencer.sv
// Iterative unsigned multiplier: folds PP_PER_CYCLE partial products per
// cycle into a registered carry-save pair, then one carry-propagate add.
// Optional macro CSA_MULT_SEQ_EARLY_TERM_EN: leave the reduce phase as soon
// as the remaining multiplier bits are all zero.
module csa_mult_sequencer
   import csa_mult_seq_pkg::*;
#(
   parameter int unsigned WIDTH        = 32,
   parameter int unsigned PP_PER_CYCLE = PP_ONE
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_prod,
   output logic                 busy
);

   localparam int unsigned PW    = 2 * WIDTH;
   localparam int unsigned N     = WIDTH / PP_PER_CYCLE;
   localparam int unsigned CNT_W = cnt_width(N);

   state_t             state_q, state_d;
   logic [PW-1:0]      mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [PW-1:0]      sum_q, sum_d;
   logic [PW-1:0]      carry_q, carry_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]      prod_q, prod_d;
   logic               valid_q, valid_d;

   // Partial products for this cycle; row gi sees the multiplicand shifted by gi
   logic [PP_PER_CYCLE-1:0][PW-1:0] pp_vec;
   logic [PW-1:0]                   row0_sum, row0_carry;
   logic [PW-1:0]                   sum_nx, carry_nx;

   genvar gi;
   generate
      for (gi = 0; gi < PP_PER_CYCLE; gi++) begin : g_pp
         assign pp_vec[gi] = mplier_q[gi] ? (mcand_q << gi) : '0;
      end
   endgenerate

   csa_row #(.W(PW)) u_row0 (
      .a_i     (sum_q),
      .b_i     (carry_q),
      .c_i     (pp_vec[0]),
      .sum_o   (row0_sum),
      .carry_o (row0_carry)
   );

   generate
      if (PP_PER_CYCLE == PP_TWO) begin : g_row1
         csa_row #(.W(PW)) u_row1 (
            .a_i     (row0_sum),
            .b_i     (row0_carry),
            .c_i     (pp_vec[PP_PER_CYCLE-1]),
            .sum_o   (sum_nx),
            .carry_o (carry_nx)
         );
      end else begin : g_row0_only
         assign sum_nx   = row0_sum;
         assign carry_nx = row0_carry;
      end
   endgenerate

   // Next-state, datapath updates and handshake outputs
   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      sum_d    = sum_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      prod_d   = prod_q;
      valid_d  = valid_q;
      in_ready = 1'b0;
      busy     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready = !rst;
            if (in_valid) begin
               mcand_d  = PW'(in_a);
               mplier_d = in_b;
               sum_d    = '0;
               carry_d  = '0;
               cnt_d    = '0;
               state_d  = ST_REDUCE;
            end
         end
         ST_REDUCE: begin
            busy     = 1'b1;
            sum_d    = sum_nx;
            carry_d  = carry_nx;
            mcand_d  = mcand_q << PP_PER_CYCLE;
            mplier_d = mplier_q >> PP_PER_CYCLE;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(N - 1)) begin
               state_d = ST_FINAL;
            end
`ifdef CSA_MULT_SEQ_EARLY_TERM_EN
            // Remaining partial products are all zero: the pair is already final
            if (mplier_d == '0) begin
               state_d = ST_FINAL;
            end
`endif
         end
         ST_FINAL: begin
            busy    = 1'b1;
            prod_d  = sum_q + carry_q;
            valid_d = 1'b1;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            // The release edge never doubles as an accept edge
            if (out_ready) begin
               valid_d = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         sum_q    <= '0;
         carry_q  <= '0;
         cnt_q    <= '0;
         prod_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         sum_q    <= sum_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         prod_q   <= prod_d;
         valid_q  <= valid_d;
      end
   end

   assign out_valid = valid_q;
   assign out_prod  = prod_q;

endmodule

// File: tb/tb_csa_mult_sequencer.sv
// Self-checking bench: two lanes (one and two partial products per cycle),
// each checked every cycle against a transaction-level model.
module tb_csa_mult_sequencer;

   localparam int W = 32;
`ifdef CSA_MULT_SEQ_EARLY_TERM_EN
   localparam bit ET = 1'b1;
`else
   localparam bit ET = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   bit lane_done [2];

   for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      localparam int PP = gi + 1;
      localparam int N  = W / PP;

      logic           rst, in_valid, in_ready, out_valid, out_ready, busy;
      logic [W-1:0]   in_a, in_b;
      logic [2*W-1:0] out_prod;

      csa_mult_sequencer #(.WIDTH(W), .PP_PER_CYCLE(PP)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid),
         .in_ready  (in_ready),
         .in_a      (in_a),
         .in_b      (in_b),
         .out_valid (out_valid),
         .out_ready (out_ready),
         .out_prod  (out_prod),
         .busy      (busy)
      );

      task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
         n_vec++;
         if (act !== exp) begin
            n_err++;
            $display("FAIL lane%0d %s: got 0x%0h want 0x%0h at %0t", gi, name, act, exp, $time);
         end
      endtask

      // Edges from acceptance to out_valid, from the multiplier value alone
      function automatic int exp_lat(input logic [31:0] b);
         int steps;
         if (!ET) return N + 1;
         steps = 1;
         while (steps < N && (b >> (PP * steps)) != 0) steps++;
         return steps + 1;
      endfunction

      // Transaction-level model: idle / working(edges left) / holding result
      bit          armed = 1'b0;
      bit          m_idle = 1'b1, m_work = 1'b0, m_valid = 1'b0;
      int          m_left = 0;
      logic [63:0] m_prod = '0, m_pend = '0;

      always @(negedge clk) begin
         if (armed) begin
            chk("in_ready",  {63'd0, in_ready},  {63'd0, m_idle && !rst});
            chk("busy",      {63'd0, busy},      {63'd0, m_work});
            chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
            chk("out_prod",  out_prod, m_prod);
         end
         if (rst) begin
            m_idle = 1'b1; m_work = 1'b0; m_valid = 1'b0; m_prod = '0; armed = 1'b1;
         end else if (m_idle) begin
            if (in_valid) begin
               m_idle = 1'b0; m_work = 1'b1;
               m_left = exp_lat(in_b);
               m_pend = 64'(in_a) * 64'(in_b);
            end
         end else if (m_work) begin
            m_left--;
            if (m_left == 0) begin
               m_work = 1'b0; m_valid = 1'b1; m_prod = m_pend;
            end
         end else if (m_valid && out_ready) begin
            $display("lane%0d product 0x%016h handed off at %0t", gi, m_prod, $time);
            m_valid = 1'b0; m_idle = 1'b1;
         end
      end

      task automatic wait_ready();
         int t = 0;
         while (!in_ready && t < 200) begin
            @(posedge clk); #1; t++;
         end
         chk("ready_timeout", {63'd0, in_ready}, 64'd1);
      endtask

      // Directed transaction with literal product and latency
      task automatic txn(input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] prod, input int lat);
         int k;
         wait_ready();
         in_a = a; in_b = b; in_valid = 1'b1;
         @(posedge clk); #1;
         in_valid = 1'b0;
         k = 0;
         do begin
            @(posedge clk); #1; k++;
         end while (!out_valid && k < 200);
         chk("latency", 64'(k), 64'(lat));
         chk("product", out_prod, prod);
         $display("lane%0d txn a=0x%08h b=0x%08h prod=0x%016h edges=%0d", gi, a, b, out_prod, k);
      endtask

      initial begin
         logic [63:0] held;
         int k;
         rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
         repeat (3) @(posedge clk);
         #1;
         chk("reset_valid", {63'd0, out_valid}, 64'd0);
         chk("reset_prod", out_prod, 64'd0);
         chk("reset_ready", {63'd0, in_ready}, 64'd0);
         rst = 1'b0;

         if (gi == 0) begin
            txn(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 33);
            txn(32'd3, 32'd5, 64'h000000000000000F, ET ? 4 : 33);
            txn(32'h00010000, 32'h00010000, 64'h0000000100000000, ET ? 18 : 33);
            txn(32'd0, 32'h80000000, 64'd0, 33);
            txn(32'hDEADBEEF, 32'd1, 64'h00000000DEADBEEF, ET ? 2 : 33);
         end else begin
            txn(32'hFFFFFFFF, 32'h12345678, 64'h12345677EDCBA988, ET ? 16 : 17);
            txn(32'hDEADBEEF, 32'd1, 64'h00000000DEADBEEF, ET ? 2 : 17);
            txn(32'd3, 32'd5, 64'h000000000000000F, ET ? 3 : 17);
         end

         // Reset in the middle of a long reduction
         wait_ready();
         in_a = 32'hCAFEF00D; in_b = 32'hFFFFFFFF; in_valid = 1'b1;
         @(posedge clk); #1; in_valid = 1'b0;
         repeat (5) @(posedge clk);
         #1; rst = 1'b1;
         repeat (2) @(posedge clk);
         #1;
         chk("midrst_valid", {63'd0, out_valid}, 64'd0);
         chk("midrst_busy", {63'd0, busy}, 64'd0);
         chk("midrst_prod", out_prod, 64'd0);
         rst = 1'b0;
         @(posedge clk); #1;
         chk("midrst_ready", {63'd0, in_ready}, 64'd1);

         // Backpressure: result must hold while new operands are offered
         out_ready = 1'b0;
         in_a = 32'h89ABCDEF; in_b = 32'h13579BDF; in_valid = 1'b1;
         held = 64'h89ABCDEF * 64'h13579BDF;
         @(posedge clk); #1; in_valid = 1'b0;
         k = 0;
         while (!out_valid && k < 200) begin
            @(posedge clk); #1; k++;
         end
         for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
            @(posedge clk); #1;
            chk("bp_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_prod", out_prod, held);
            chk("bp_ready", {63'd0, in_ready}, 64'd0);
         end
         out_ready = 1'b1;
         @(posedge clk); #1;
         chk("bp_release_ready", {63'd0, in_ready}, 64'd1);
         in_valid = 1'b0;

         // Randomized traffic, checked by the per-cycle model
         for (int c = 0; c < 1500; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_a      = $urandom;
            in_b      = $urandom >> $urandom_range(0, 31);
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 399) == 0);
            @(posedge clk); #1;
         end
         rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
         repeat (40) @(posedge clk);
         lane_done[gi] = 1'b1;
      end
   end

   initial begin
      int cyc = 0;
      while (!(lane_done[0] && lane_done[1]) && cyc < 60000) begin
         @(posedge clk); cyc++;
      end
      n_vec++;
      if (!(lane_done[0] && lane_done[1])) begin
         n_err++;
         $display("FAIL run_timeout: lanes done=%0b%0b want 11", lane_done[1], lane_done[0]);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/csa_mult_sequencer.md
Name: csa_mult_sequencer

Overview:
Iterative unsigned multiplier controller that time-shares one 2*WIDTH-bit carry-save 3:2 row. Each cycle it folds PP_PER_CYCLE partial products into a registered (sum, carry) pair, then does one carry-propagate add. It is the area-optimised companion to the fully pipelined Wallace-tree multiplier, with a valid/ready handshake on both sides.

Parameters:
WIDTH, 32, operand width in bits; the product is 2*WIDTH bits.
PP_PER_CYCLE, 1, partial products reduced per cycle; legal values are 1 or 2. The value 2 chains two CSA rows. WIDTH must be divisible by PP_PER_CYCLE.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand pair is valid.
in_ready  output  1  block accepts operands; high only in IDLE while rst is low.
in_a  input  WIDTH  multiplicand (unsigned).
in_b  input  WIDTH  multiplier (unsigned).
out_valid  output  1  product is valid; held until accepted.
out_ready  input  1  consumer accepts the product.
out_prod  output  2*WIDTH  in_a*in_b; registered.
busy  output  1  high in REDUCE or FINAL.

Behaviour:
- Clock and reset are fixed: one clock `clk`; `rst` is synchronous and active-high.
- Reset (rst high at an edge):
  - state goes to IDLE.
  - out_valid=0, out_prod=0, busy=0.
  - sum, carry, counter and operand registers clear.
  - in_ready=0 while rst is high.
  - Reset mid-operation aborts the operation; no partial result ever appears.
- States: IDLE, REDUCE, FINAL, DONE.
- IDLE: in_ready=1.
  - On an edge with in_valid&in_ready: mcand = zero-extended in_a (2*WIDTH bits), mplier = in_b, sum=0, carry=0, cnt=0, then go to REDUCE.
  - in_valid without acceptance has no effect.
- REDUCE: each edge does the following.
  - pp0 = mplier[0] ? mcand : 0.
  - If PP_PER_CYCLE=2: pp1 = mplier[1] ? mcand<<1 : 0, applied through a second row.
  - CSA update: s' = sum^carry^pp, c' = majority(sum,carry,pp)<<1. Bit 0 of c' is 0 and the top carry-out is discarded (arithmetic mod 2^(2*WIDTH)).
  - mcand <<= PP_PER_CYCLE, mplier >>= PP_PER_CYCLE, cnt++.
  - Go to FINAL when cnt == N-1, where N = WIDTH/PP_PER_CYCLE.
- FINAL: one edge; out_prod <= sum+carry (2*WIDTH bits, carry-out dropped), out_valid <= 1, then go to DONE.
- DONE: out_valid=1.
  - out_prod is stable and in_ready=0.
  - On an edge with out_ready: out_valid <= 0, then go to IDLE.
  - No new operand is accepted in that same edge.
- Latency: out_valid rises at the (N+1)th edge after the accepting edge (33 for the defaults). Throughput is one product per N+3 cycles minimum.
- out_ready while not in DONE is ignored.

Optional Feature:
CSA_MULT_SEQ_EARLY_TERM_EN
- Defined: REDUCE also goes to FINAL when the post-shift mplier is zero. Minimum latency is 2 edges; the product is unchanged.
- Undefined: latency is always N+1 edges, independent of operand values.

Decomposition:
- Package csa_mult_seq_pkg holds:
  - the state enum type (IDLE/REDUCE/FINAL/DONE, 2 bits);
  - function clog2-based counter width;
  - constants for legal PP_PER_CYCLE values.
- One sub-module, csa_row: parameterised 3:2 carry-save row producing sum and shifted carry, with the carry-out dropped. It is instantiated PP_PER_CYCLE times in a chain.

Test Plan:
- Reset: pulse rst for 2 cycles mid-REDUCE. Required: out_valid=0, busy=0, out_prod=0; in_ready=1 one cycle after rst falls; no product emitted.
- A=0xFFFFFFFF, B=0xFFFFFFFF with out_ready=1. Required: out_prod=0xFFFFFFFE00000001; out_valid at edge 33 after acceptance (no EARLY_TERM).
- A=3, B=5 → 0x000000000000000F. A=0x00010000, B=0x00010000 → 0x0000000100000000. A=0, B=0x80000000 → 0.
- Backpressure: out_ready=0 for 10 cycles with in_valid=1 and changing operands. Required: out_prod and out_valid stable, in_ready=0; after out_ready=1, in_ready rises the next cycle.
- EARLY_TERM, A=0xDEADBEEF, B=1. Required: 0x00000000DEADBEEF at edge 2 with the macro, edge 33 without.
- PP_PER_CYCLE=2, A=0xFFFFFFFF, B=0x12345678. Required: out_prod=0x12345677EDCBA988; out_valid at edge 17.
